// File: rtl/bus_decode_ctrl.sv
// Memory-map decoder and bus-cycle controller: one-hot region enables, per-region wait states, read-data latch.
// Optional feature macro BUS_ERR_COUNT_EN adds a saturating err_count output counting bus_err pulses.
module bus_decode_ctrl #(
    parameter int NREG   = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 4,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE = {16'hF000, 16'h8000, 16'h4000, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hF000, 16'hC000, 16'hC000},
    parameter logic [NREG*WAIT_W-1:0] REGION_WAIT = {4'd1, 4'd3, 4'd0, 4'd0}
) (
    input  logic                   CLOCK_50,
    input  logic                   res,
    input  logic                   bus_req,
    input  logic [ADDR_W-1:0]      cpu_adr,
    input  logic                   cpu_rw,
    input  logic [DATA_W-1:0]      cpu_dbo,
    input  logic [NREG*DATA_W-1:0] mem_dbi,
    output logic [NREG-1:0]        ce,
    output logic                   we,
    output logic [DATA_W-1:0]      mem_dbo,
    output logic [DATA_W-1:0]      cpu_dbi,
    output logic                   rdy,
    output logic                   bus_err
`ifdef BUS_ERR_COUNT_EN
    ,
    output logic [7:0]             err_count
`endif
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE = 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, next_state;
    logic [NREG-1:0]   hit;
    logic [IDX_W-1:0]  hit_idx, idx_q;
    logic [WAIT_W-1:0] hit_wait, cnt_q;
    logic              any_hit, rw_q, accept;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NREG; i++)
            hit[i] = ((cpu_adr ^ REGION_BASE[i*ADDR_W +: ADDR_W]) & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0;
    end

    // Scanning downwards lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit_idx = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (hit[i]) hit_idx = IDX_W'(i);
    end

    assign any_hit  = |hit;
    assign hit_wait = REGION_WAIT[int'(hit_idx)*WAIT_W +: WAIT_W];
    assign accept   = bus_req && (state != ACCESS);

    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = (bus_req && any_hit) ? ACCESS : IDLE;
            ACCESS:     next_state = (cnt_q == '0) ? DONE : ACCESS;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        ce  = '0;
        we  = 1'b0;
        rdy = 1'b1;
        if (state == ACCESS) begin
            ce[idx_q] = 1'b1;
            we        = ~rw_q;
            rdy       = 1'b0;
        end
    end

    // The wait counter only counts down to zero, so the largest wait value never wraps.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            idx_q   <= '0;
            rw_q    <= 1'b1;
            cnt_q   <= '0;
            mem_dbo <= '0;
            cpu_dbi <= '1;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (accept) begin
                if (any_hit) begin
                    idx_q   <= hit_idx;
                    rw_q    <= cpu_rw;
                    cnt_q   <= hit_wait;
                    mem_dbo <= cpu_dbo;
                end else begin
                    bus_err <= 1'b1;
                    cpu_dbi <= '1;
                end
            end else if (state == ACCESS) begin
                if (cnt_q != '0)
                    cnt_q <= cnt_q - WAIT_ONE;
                else if (rw_q)
                    cpu_dbi <= mem_dbi[int'(idx_q)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_ERR_COUNT_EN
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res)
            err_count <= 8'd0;
        else if (accept && !any_hit && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule
